// File: rtl/tx_frame_scheduler_pkg.sv
// Shared types and constants for the transmit frame scheduler and its arbiters.
package tx_frame_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_LOAD     = 3'b001,
        S_SEND     = 3'b010,
        S_CHECK    = 3'b011,
        S_WAIT_END = 3'b100,
        S_RETRY    = 3'b101,
        S_RELEASE  = 3'b110
    } sched_state_e;

    localparam int unsigned DEF_TIMEOUT   = 2047;
    localparam int unsigned DEF_MAX_RETRY = 3;
    localparam int unsigned FRAME_BITS    = 10;
    localparam int unsigned BIT_CYCLES    = 106;
    localparam int unsigned FRAME_CYCLES  = FRAME_BITS * BIT_CYCLES;

    function automatic int unsigned rr_wrap(input int unsigned v, input int unsigned n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_rr_pick.sv
// Rotate-priority selector: first set req bit scanning upward from last_id+1, wrapping.
module rr_pick
    import tx_frame_scheduler_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_id,
    output logic           valid,
    output logic [IDW-1:0] id
);

    int unsigned      pos;
    logic [IDW-1:0]   idx;

    // Scan from the farthest candidate back to the nearest so the nearest hit wins.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        pos   = '0;
        idx   = '0;
        for (int unsigned k = N; k >= 1; k--) begin
            pos = rr_wrap(32'(last_id) + k, N);
            idx = IDW'(pos);
            if (req[idx]) begin
                valid = 1'b1;
                id    = idx;
            end
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing one serial byte transmitter between N_REQ producers.
module tx_frame_scheduler
    import tx_frame_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_RETRY = DEF_MAX_RETRY,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    localparam int unsigned IDW      = $clog2(N_REQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic               dsr,
    input  logic               tx_end,
    input  logic               tx_error,
    output logic               tx_load,
    output logic [7:0]         tx_data,
    output logic               tx_send,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   fail,
    output logic               busy,
    output logic [IDW-1:0]     cur_id
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    sched_state_e     state_q, state_d;
    logic [IDW-1:0]   cur_id_q, cur_id_d;
    logic [IDW-1:0]   last_id_q, last_id_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [RW-1:0]    retry_cnt_q, retry_cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             ok_q, ok_d;
    logic             tx_load_q, tx_load_d;
    logic             tx_send_q, tx_send_d;
    logic             busy_q, busy_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] fail_q, fail_d;
    logic [N_REQ-1:0] id_onehot;

    logic             pick_valid;
    logic [IDW-1:0]   pick_id;

    rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick (
        .req     (req),
        .last_id (last_id_q),
        .valid   (pick_valid),
        .id      (pick_id)
    );

    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        last_id_d   = last_id_q;
        tx_data_d   = tx_data_q;
        retry_cnt_d = retry_cnt_q;
        timer_d     = timer_q;
        ok_d        = ok_q;

        unique case (state_q)
            S_IDLE: begin
                if (dsr && pick_valid) begin
                    cur_id_d    = pick_id;
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (IDW'(i) == pick_id) tx_data_d = req_data[8*i +: 8];
                    end
                    retry_cnt_d = '0;
                    ok_d        = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD:  state_d = S_SEND;
            S_SEND:  state_d = S_CHECK;
            S_CHECK: begin
                if (tx_error) begin
                    state_d = S_RETRY;
                end else begin
                    timer_d = '0;
                    state_d = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (timer_q != TW'(TIMEOUT)) timer_d = timer_q + 1'b1;
                if (tx_end) begin
                    ok_d    = 1'b1;
                    state_d = S_RELEASE;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    state_d = S_RETRY;
                end
            end
            S_RETRY: begin
                if (retry_cnt_q == RW'(MAX_RETRY)) begin
                    ok_d    = 1'b0;
                    state_d = S_RELEASE;
                end else if (dsr) begin
                    retry_cnt_d = retry_cnt_q + 1'b1;
                    state_d     = S_LOAD;
                end
            end
            S_RELEASE: begin
                last_id_d = cur_id_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are flops fed from the next state, so they line up with state_q exactly.
    always_comb begin
        id_onehot           = '0;
        id_onehot[cur_id_d] = 1'b1;
        tx_load_d = (state_d == S_LOAD);
        tx_send_d = (state_d == S_SEND);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_RELEASE &&  ok_d) ? id_onehot : '0;
        fail_d    = (state_d == S_RELEASE && !ok_d) ? id_onehot : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cur_id_q    <= '0;
            last_id_q   <= IDW'(N_REQ - 1);
            tx_data_q   <= '0;
            retry_cnt_q <= '0;
            timer_q     <= '0;
            ok_q        <= 1'b0;
            tx_load_q   <= 1'b0;
            tx_send_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= '0;
            fail_q      <= '0;
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            last_id_q   <= last_id_d;
            tx_data_q   <= tx_data_d;
            retry_cnt_q <= retry_cnt_d;
            timer_q     <= timer_d;
            ok_q        <= ok_d;
            tx_load_q   <= tx_load_d;
            tx_send_q   <= tx_send_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    assign tx_load = tx_load_q;
    assign tx_send = tx_send_q;
    assign tx_data = tx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign fail    = fail_q;
    assign cur_id  = cur_id_q;

endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Round-robin scheduler that shares one serial byte transmitter (load/send/tx_end/error handshake, 10-bit start/8-data/stop frame) between `N_REQ` byte producers, such as ADC channel readers. It grants one requester at a time, drives the transmitter's load and send strobes, checks the transmitter's error flag, waits for frame completion with a timeout, and retries a bounded number of times. It sits between the acquisition FSMs and the transmitter's interface/shift-out logic.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `MAX_RETRY`, 3: retries after the first attempt; up to `MAX_RETRY+1` attempts in total.
- `TIMEOUT`, 2047: WAIT_END cycle limit. Must exceed one frame, about 10×106 cycles.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in N_REQ: level request per requester. Must stay high, with `req_data` stable, until that requester's `done` or `fail`.
- `req_data` in 8*N_REQ: byte i is `req_data[8i+7:8i]`.
- `dsr` in 1: peer ready. Needed to start or restart an attempt.
- `tx_end` in 1: one-cycle frame-complete pulse from the transmitter.
- `tx_error` in 1: transmitter error flag.
- `tx_load` out 1: one-cycle load strobe.
- `tx_data` out 8: latched byte, valid from LOAD until the next grant.
- `tx_send` out 1: one-cycle send strobe.
- `done` out N_REQ: one-hot success pulse.
- `fail` out N_REQ: one-hot failure pulse.
- `busy` out 1: high in every state except IDLE.
- `cur_id` out clog2(N_REQ): index of the granted requester.

## Operation
- Reset values: state IDLE, all outputs 0, `retry_cnt` 0, `timer` 0, `last_id` = N_REQ-1, so requester 0 is served first.
- All outputs are registered and decoded from the state, Moore style.
- IDLE:
  - If `dsr` and `|req`, select the first set `req` bit scanning from `last_id+1` modulo N_REQ.
  - Latch `cur_id` and `tx_data`, clear `retry_cnt`, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: `tx_load`=1, go to SEND.
- SEND: `tx_send`=1, go to CHECK.
- CHECK: sample `tx_error`.
  - If 1, go to RETRY.
  - Otherwise clear `timer` and go to WAIT_END.
- WAIT_END: `timer`++ each cycle.
  - If `tx_end`, set the success flag and go to RELEASE.
  - Else if `timer`==TIMEOUT, go to RETRY.
- RETRY:
  - If `retry_cnt`==MAX_RETRY, set the fail flag and go to RELEASE.
  - Else if `dsr`, `retry_cnt`++ and go to LOAD.
  - Else stay in RETRY.
- RELEASE: lasts exactly one cycle.
  - `done[cur_id]` or `fail[cur_id]` = 1.
  - `last_id` = `cur_id`.
  - Go to IDLE.
  - The requester drops `req` at the edge ending RELEASE, so IDLE never re-grants the same byte.
- Width rules:
  - `timer` is clog2(TIMEOUT+1) bits and saturates at TIMEOUT (no wrap).
  - `retry_cnt` is clog2(MAX_RETRY+1) bits.
  - The round-robin index wraps N_REQ-1 → 0.

## Timing
- With `req`/`dsr` sampled high in IDLE at cycle 0: `tx_load` in cycle 1, `tx_send` in cycle 2, `tx_error` sampled in cycle 3.
- `done` is asserted in the cycle after `tx_end`. Next grant possible 2 cycles after `tx_end`.
- `tx_end` and `timer`==TIMEOUT in the same cycle: `tx_end` wins (success).
- `tx_end` or `tx_error` outside WAIT_END / CHECK: ignored.
- `dsr` falling during LOAD, SEND or WAIT_END: ignored. It is only checked in IDLE and RETRY.
- `req` dropping mid-transfer violates the protocol. The scheduler still completes and pulses `done`/`fail`.
- Reset mid-frame: immediate return to IDLE, strobes deasserted, no `done`/`fail` for the aborted byte.

## Structure
- Shared package holds:
  - state encoding, 3 bits: IDLE 000, LOAD 001, SEND 010, CHECK 011, WAIT_END 100, RETRY 101, RELEASE 110;
  - default TIMEOUT / MAX_RETRY constants;
  - frame length constant (10 bits × 106 cycles).
- One sub-module, `rr_pick`: combinational rotate-priority selector with inputs `req` and `last_id`, outputs `valid` and `id`. It is reused by later arbiters.

## Test plan
- Single byte: requester 2 sends 0xA5, `dsr`=1, `tx_end` at cycle 1100 → `tx_load` at cycle 1, `tx_send` at cycle 2, `tx_data`=0xA5, `cur_id`=2, `done[2]` at cycle 1101, `busy` low at cycle 1102.
- Fairness: `req`=4'b1111 held and refilled after each `done` → grant order 0,1,2,3,0; no requester served twice in a row while others are pending.
- Error retry: `tx_error`=1 in CHECK on the first two attempts, clean on the third → three `tx_load` pulses, `retry_cnt`=2, then `done`.
- Exhausted: `tx_error` always 1 with MAX_RETRY=3 → four attempts, then `fail[id]` pulse, `done` never asserted, next requester granted.
- Timeout: no `tx_end` → RETRY at WAIT_END cycle 2047; `tx_end` coinciding with `timer`==2047 → `done`, not a retry.
- Reset/`dsr`: `reset_n` low in WAIT_END → all outputs 0 and state IDLE immediately. `dsr`=0 with `req` high → no grant until `dsr` rises, then `tx_load` 1 cycle later.
